// File: rtl/weight_load_control_unit_pkg.sv
// Shared types and sizing for the weight loader feeding the systolic MAC array.
package tpu_package;
    localparam int MUL_SIZE   = 32;
    localparam int WL_MAX_OCC = 2;
    localparam int WL_ROW_W   = $clog2(MUL_SIZE);

    typedef enum logic [2:0] {
        WL_IDLE,
        WL_FETCH,
        WL_DRAIN,
        WL_WAIT_SLOT,
        WL_FINISH
    } weight_load_state_t;
endpackage

// File: rtl/weight_tile_slot_tracker.sv
// Counts loaded-but-unconsumed weight tiles (0..2) in the array's double buffer.
// WEIGHT_LOAD_ERR_EN enables detection of a retire request while empty.
module weight_tile_slot_tracker
    import tpu_package::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] occ_o,
    output logic [1:0] occ_next_o,
    output logic       rdy_o,
    output logic       underflow_o
);
    logic dec_ok;

    assign dec_ok = dec_i && (occ_o != 2'd0);

    // A load landing in the same cycle as a retire leaves the count unchanged.
    always_comb begin
        occ_next_o = occ_o;
        if (inc_i && !dec_ok)
            occ_next_o = occ_o + 2'd1;
        else if (!inc_i && dec_ok)
            occ_next_o = occ_o - 2'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            occ_o <= 2'd0;
        else
            occ_o <= occ_next_o;
    end

    assign rdy_o = (occ_o != 2'd0);

`ifdef WEIGHT_LOAD_ERR_EN
    assign underflow_o = dec_i && (occ_o == 2'd0);
`else
    assign underflow_o = 1'b0;
`endif
endmodule

// File: rtl/weight_load_control_unit.sv
// Streams weight tiles from weight memory into the array's double-buffered registers.
// Optional macro WEIGHT_LOAD_ERR_EN: sticky err_o on retire-while-empty or start-while-busy.
module weight_load_control_unit
    import tpu_package::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [6:0]                 num_tiles_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    output logic                       mem_rd_en_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic [MUL_SIZE*DATA_W-1:0] mem_rd_data_i,
    output logic [MUL_SIZE*DATA_W-1:0] weight_row_o,
    output logic                       weight_row_valid_o,
    output logic [WL_ROW_W-1:0]        weight_row_idx_o,
    output logic                       weight_bank_o,
    output logic                       compute_weights_rdy_o,
    input  logic                       next_weight_tile_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam logic [WL_ROW_W-1:0] LAST_ROW = WL_ROW_W'(MUL_SIZE - 1);
    localparam logic [1:0]          MAX_OCC  = 2'(WL_MAX_OCC);

    weight_load_state_t  state;
    logic [WL_ROW_W-1:0] row_cnt;
    logic [6:0]          tiles_left;
    logic [1:0]          occ;
    logic [1:0]          occ_next;
    logic                underflow;

    weight_tile_slot_tracker u_slots (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (state == WL_DRAIN),
        .dec_i       (next_weight_tile_i),
        .occ_o       (occ),
        .occ_next_o  (occ_next),
        .rdy_o       (compute_weights_rdy_o),
        .underflow_o (underflow)
    );

    assign weight_row_o = mem_rd_data_i;
    assign busy_o       = (state != WL_IDLE);

    // mem_addr_o keeps advancing past the last row so it already holds the next tile's base.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= WL_IDLE;
            row_cnt            <= '0;
            tiles_left         <= '0;
            mem_rd_en_o        <= 1'b0;
            mem_addr_o         <= '0;
            weight_row_valid_o <= 1'b0;
            weight_row_idx_o   <= '0;
            weight_bank_o      <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            done_o             <= 1'b0;
            weight_row_valid_o <= mem_rd_en_o;
            weight_row_idx_o   <= row_cnt;
            case (state)
                WL_IDLE: begin
                    if (start_i) begin
                        if (num_tiles_i == 7'd0) begin
                            done_o <= 1'b1;
                        end else begin
                            state       <= WL_FETCH;
                            tiles_left  <= num_tiles_i;
                            mem_addr_o  <= base_addr_i;
                            mem_rd_en_o <= 1'b1;
                            row_cnt     <= '0;
                        end
                    end
                end
                WL_FETCH: begin
                    mem_addr_o <= mem_addr_o + 1'b1;
                    if (row_cnt == LAST_ROW) begin
                        mem_rd_en_o <= 1'b0;
                        row_cnt     <= '0;
                        state       <= WL_DRAIN;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                WL_DRAIN: begin
                    weight_bank_o <= ~weight_bank_o;
                    tiles_left    <= tiles_left - 7'd1;
                    if (tiles_left == 7'd1) begin
                        state <= WL_FINISH;
                    end else if (occ_next < MAX_OCC) begin
                        state       <= WL_FETCH;
                        mem_rd_en_o <= 1'b1;
                    end else begin
                        state <= WL_WAIT_SLOT;
                    end
                end
                WL_WAIT_SLOT: begin
                    if (occ_next < MAX_OCC) begin
                        state       <= WL_FETCH;
                        mem_rd_en_o <= 1'b1;
                    end
                end
                WL_FINISH: begin
                    if (occ_next == 2'd0) begin
                        done_o <= 1'b1;
                        state  <= WL_IDLE;
                    end
                end
                default: state <= WL_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_LOAD_ERR_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            err_q <= 1'b0;
        else if (underflow || (start_i && busy_o))
            err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = underflow;
`endif
endmodule

// File: doc/weight_load_control_unit.md
# weight_load_control_unit

Producer side of the weight handshake into the systolic MAC array. Fetches weight tiles (MUL_SIZE rows each) from on-chip weight memory, streams rows into the array's double-buffered weight registers, and asserts `compute_weights_rdy_o` while at least one loaded tile is unconsumed. Retires a tile on each `next_weight_tile_i` pulse from the compute controller, keeping up to two tiles resident (active plus shadow).

## Interface
- `MUL_SIZE`, default 32 (package): array dimension; rows per tile.
- `DATA_W`, default 8: bits per weight.
- `ADDR_W`, default 12: weight memory row address width.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse; latches `num_tiles_i` and `base_addr_i`; honoured only in IDLE.
- `num_tiles_i` in 7: tiles in the job; 0 means no-op.
- `base_addr_i` in ADDR_W: row address of tile 0 row 0.
- `mem_rd_en_o` out 1: weight memory read strobe.
- `mem_addr_o` out ADDR_W: read address.
- `mem_rd_data_i` in MUL_SIZE*DATA_W: read data, valid exactly 1 cycle after `mem_rd_en_o`.
- `weight_row_o` out MUL_SIZE*DATA_W: row to array (combinational pass-through of `mem_rd_data_i`).
- `weight_row_valid_o` out 1: `weight_row_o` valid this cycle.
- `weight_row_idx_o` out $clog2(MUL_SIZE): destination row.
- `weight_bank_o` out 1: destination buffer bank of the tile being written.
- `compute_weights_rdy_o` out 1: occupancy != 0.
- `next_weight_tile_i` in 1: one-cycle pulse; active tile consumed.
- `busy_o` out 1: state != IDLE.
- `done_o` out 1: one-cycle pulse at job end.
- `err_o` out 1: sticky protocol error (see Configuration).

## Operation
- States: IDLE, FETCH, DRAIN, WAIT_SLOT, FINISH.
- IDLE: on `start_i` with `num_tiles_i` != 0 -> FETCH; tiles_left = `num_tiles_i`, addr = `base_addr_i`. `start_i` with 0 -> `done_o` pulse next cycle, stay IDLE.
- FETCH: `mem_rd_en_o`=1 every cycle, addr += 1, row counter 0..MUL_SIZE-1; after row MUL_SIZE-1 issued -> DRAIN.
- DRAIN (1 cycle, last row returning): occupancy += 1, tiles_left -= 1, `weight_bank_o` toggles; then tiles_left==0 -> FINISH, occupancy<2 -> FETCH, else WAIT_SLOT.
- WAIT_SLOT: occupancy==2; leaves to FETCH the cycle after occupancy drops below 2.
- FINISH: waits for occupancy==0, pulses `done_o`, -> IDLE.
- Occupancy 0..2 (2-bit): +1 in DRAIN, -1 on `next_weight_tile_i` when nonzero; simultaneous -> unchanged. `next_weight_tile_i` at 0 ignored.
- `start_i` outside IDLE ignored. Address wraps modulo 2^ADDR_W.

## Timing
- Reset values: all outputs 0, state IDLE, occupancy 0, `weight_bank_o` 0; reset mid-fetch drops `mem_rd_en_o` immediately (async), no partial-tile retirement.
- `start_i` at cycle 0 -> first `mem_rd_en_o` cycle 1; row r valid on `weight_row_valid_o` cycle 2+r; `compute_weights_rdy_o` rises cycle MUL_SIZE+2 (34 at default).
- Back-to-back tiles: 1 DRAIN bubble between fetches -> MUL_SIZE+1 cycles per tile.
- `weight_row_valid_o` = registered `mem_rd_en_o`; `weight_row_idx_o` registered with it.

## Configuration
- `WEIGHT_LOAD_ERR_EN`: defined -> `err_o` set on `next_weight_tile_i` at occupancy 0 or `start_i` while busy; cleared only by reset. Undefined -> `err_o` tied 0, no checking logic.

## Structure
- `tpu_package`: `MUL_SIZE`, a `weight_load_state_t` enum, `WL_MAX_OCC = 2`.
- One sub-module `weight_tile_slot_tracker`: occupancy counter, increment/decrement, rdy and error-on-empty detection.

## Test plan
- `num_tiles_i`=1, base 0x010, consume at cycle 40 -> reads 0x010..0x02F, rdy high cycles 34..40, `done_o` cycle 41.
- `num_tiles_i`=3, no consume -> two tiles load, WAIT_SLOT, `mem_rd_en_o` idle; one pulse -> third fetch starts next cycle.
- DRAIN coincident with `next_weight_tile_i` at occupancy 1 -> occupancy stays 1, rdy never drops.
- `num_tiles_i`=0 -> no reads, `done_o` cycle 1, `busy_o` stays 0.
- `rst_i` low mid-FETCH row 10 -> all outputs 0 same cycle; new `start_i` restarts at row 0.
- With `WEIGHT_LOAD_ERR_EN`, `next_weight_tile_i` at occupancy 0 -> `err_o`=1 until reset; without, `err_o`=0.
